// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer for the 16-bit CPU.
// Fetches instruction words over a req/ready port, holds PC and IR', drives the
// fetch/exec1/exec2 strobes and owns the CARRY and SKIP flops.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   run                        1 = execute, 0 = halt at next instruction boundary
//   mem_rdata, mem_ready       instruction word and fetch-complete handshake
//   alu_carryout, alu_carryen  CARRY D input and enable (honoured in EXEC1 only)
//   alu_skipout, alu_skipen    SKIP D input and enable (honoured in EXEC1 only)
//   mem_req, mem_addr          fetch request (held until ready) and address (= pc)
//   ir                         instruction register IR'
//   fetch, exec1, exec2        state strobes
//   carrystatus, skipstatus    CARRY and SKIP flop outputs
//   halted                     1 while idle
module cpu_sequencer #(
    parameter int PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ready,
    input  logic                alu_carryout,
    input  logic                alu_carryen,
    input  logic                alu_skipout,
    input  logic                alu_skipen,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [15:0]         ir,
    output logic                fetch,
    output logic                exec1,
    output logic                exec2,
    output logic                carrystatus,
    output logic                skipstatus,
    output logic                halted
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC1, EXEC2} state_t;
    state_t state, state_n, done_next;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [15:0] ir_n;
    logic carry, carry_n, skip, skip_n;
    // run is only looked at when an instruction finishes
    assign done_next = run ? FETCH : IDLE;
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        carry_n = carry;
        skip_n  = skip;
        case (state)
            IDLE:  state_n = run ? FETCH : IDLE;
            FETCH: if (mem_ready) begin
                ir_n    = mem_rdata;
                pc_n    = pc + PC_WIDTH'(1);
                // a pending SKIP swallows this word without any exec strobes
                skip_n  = 1'b0;
                state_n = skip ? done_next : EXEC1;
            end
            EXEC1: begin
                carry_n = alu_carryen ? alu_carryout : carry;
                skip_n  = alu_skipen ? alu_skipout : skip;
                if (ir[15:14] == 2'b10)
                    pc_n = PC_WIDTH'({{PC_WIDTH{1'b0}}, ir[13:0]});
                state_n = ir[15] ? done_next : EXEC2;
            end
            default: state_n = done_next;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            carry <= 1'b0;
            skip  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            carry <= carry_n;
            skip  <= skip_n;
        end
    end
    assign mem_req     = state == FETCH;
    assign fetch       = state == FETCH;
    assign exec1       = state == EXEC1;
    assign exec2       = state == EXEC2;
    assign halted      = state == IDLE;
    assign mem_addr    = pc;
    assign carrystatus = carry;
    assign skipstatus  = skip;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scenario and randomized checks of cpu_sequencer against an instruction-level model.
module tb_cpu_sequencer;
    localparam logic [15:0] RPC = 16'hFFFE;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic mem_ready = 1'b0;
    logic alu_carryout = 1'b0;
    logic alu_carryen = 1'b0;
    logic alu_skipout = 1'b0;
    logic alu_skipen = 1'b0;
    logic mem_req, fetch, exec1, exec2, carrystatus, skipstatus, halted;
    logic [15:0] mem_addr, ir;
    int total = 0;
    int bad = 0;
    // model: idle flag, exec cycle index of current instruction (0 = fetching), architectural state
    logic m_idle;
    int ex;
    logic [15:0] m_pc, m_ir;
    logic m_c, m_s;
    cpu_sequencer #(.PC_WIDTH(16), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_carryout(alu_carryout), .alu_carryen(alu_carryen), .alu_skipout(alu_skipout),
        .alu_skipen(alu_skipen), .mem_req(mem_req), .mem_addr(mem_addr), .ir(ir), .fetch(fetch),
        .exec1(exec1), .exec2(exec2), .carrystatus(carrystatus), .skipstatus(skipstatus), .halted(halted)
    );
    always #5 clk = ~clk;
    task model_reset;
        m_idle = 1'b1;
        ex = 0;
        m_pc = RPC;
        m_ir = '0;
        m_c = 1'b0;
        m_s = 1'b0;
    endtask
    task finish_instr(input logic r);
        m_idle = !r;
        ex = 0;
    endtask
    task tick(input logic r, input logic rdy, input logic [15:0] d,
              input logic ce, input logic co, input logic se, input logic so);
        run = r;
        mem_ready = rdy;
        mem_rdata = d;
        alu_carryen = ce;
        alu_carryout = co;
        alu_skipen = se;
        alu_skipout = so;
        if (m_idle) begin
            if (r) finish_instr(1'b1);
        end else if (ex == 0) begin
            if (rdy) begin
                m_ir = d;
                m_pc = m_pc + 16'd1;
                if (m_s) begin
                    m_s = 1'b0;
                    finish_instr(r);
                end else ex = 1;
            end
        end else if (ex == 1) begin
            if (ce) m_c = co;
            if (se) m_s = so;
            case (m_ir[15:14])
                2'b11: finish_instr(r);
                2'b10: begin m_pc = {2'b00, m_ir[13:0]}; finish_instr(r); end
                default: ex = 2;
            endcase
        end else finish_instr(r);
        @(posedge clk);
        #1;
    endtask
    task alu(input logic r, input logic rdy, input logic [15:0] d);
        tick(r, rdy, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task test_reset;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({halted, fetch, mem_req, exec1, exec2, carrystatus, skipstatus} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=1000000", {halted, fetch, mem_req, exec1, exec2, carrystatus, skipstatus});
        end
        total++;
        if (mem_addr !== RPC || ir !== 16'h0000) begin
            bad++;
            $display("FAIL reset_regs got pc=%h ir=%h want pc=%h ir=0000", mem_addr, ir, RPC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (halted !== 1'b1) begin bad++; $display("FAIL idle_hold got halted=%b want 1", halted); end
    endtask
    task test_alu_stream;
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (fetch !== 1'b1 || mem_req !== 1'b1 || mem_addr !== RPC) begin
            bad++;
            $display("FAIL stream_start got fetch=%b req=%b addr=%h want 1 1 %h", fetch, mem_req, mem_addr, RPC);
        end
        for (int i = 1; i <= 7; i++) begin
            alu(1'b1, 1'b1, 16'hC000);
            total++;
            if (exec1 !== logic'(i % 2) || fetch !== logic'(1 - i % 2) || mem_addr !== m_pc) begin
                bad++;
                $display("FAIL stream_cycle%0d got exec1=%b fetch=%b addr=%h want %b %b %h", i, exec1, fetch, mem_addr, logic'(i % 2), logic'(1 - i % 2), m_pc);
            end
        end
        total++;
        if (mem_addr !== 16'h0002 || ir !== 16'hC000) begin
            bad++;
            $display("FAIL stream_wrap got addr=%h ir=%h want 0002 C000", mem_addr, ir);
        end
    endtask
    task test_wait_states;
        int n;
        n = 0;
        while (!(!m_idle && ex == 0 && m_pc == 16'd5) && n < 40) begin
            alu(1'b1, 1'b1, 16'hC000);
            n++;
        end
        total++;
        if (n >= 40) begin bad++; $display("FAIL wait_reach got pc=%h want 0005", m_pc); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || exec1 !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold%0d got req=%b addr=%h exec1=%b want 1 0005 0", i, mem_req, mem_addr, exec1);
            end
            if (i < 3) alu(1'b1, 1'b0, 16'h1234);
        end
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (exec1 !== 1'b1 || mem_addr !== 16'h0006) begin
            bad++;
            $display("FAIL wait_done got exec1=%b addr=%h want 1 0006", exec1, mem_addr);
        end
    endtask
    task test_skip;
        tick(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if (skipstatus !== 1'b1 || fetch !== 1'b1) begin
            bad++;
            $display("FAIL skip_set got skip=%b fetch=%b want 1 1", skipstatus, fetch);
        end
        alu(1'b1, 1'b1, 16'hC0DE);
        total++;
        if (fetch !== 1'b1 || exec1 !== 1'b0 || skipstatus !== 1'b0 || mem_addr !== 16'h0007 || ir !== 16'hC0DE) begin
            bad++;
            $display("FAIL skip_discard got fetch=%b exec1=%b skip=%b addr=%h ir=%h want 1 0 0 0007 C0DE", fetch, exec1, skipstatus, mem_addr, ir);
        end
    endtask
    task test_jump_two_cycle;
        alu(1'b1, 1'b1, 16'h8123);
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (fetch !== 1'b1 || mem_addr !== 16'h0123) begin
            bad++;
            $display("FAIL jump_target got fetch=%b addr=%h want 1 0123", fetch, mem_addr);
        end
        alu(1'b1, 1'b1, 16'h4000);
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (exec2 !== 1'b1 || exec1 !== 1'b0 || mem_addr !== 16'h0124) begin
            bad++;
            $display("FAIL two_cycle_exec2 got exec2=%b exec1=%b addr=%h want 1 0 0124", exec2, exec1, mem_addr);
        end
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (fetch !== 1'b1 || exec2 !== 1'b0) begin
            bad++;
            $display("FAIL two_cycle_back got fetch=%b exec2=%b want 1 0", fetch, exec2);
        end
        alu(1'b1, 1'b1, 16'h8200);
        tick(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        alu(1'b1, 1'b1, 16'hC000);
        total++;
        if (fetch !== 1'b1 || exec1 !== 1'b0 || mem_addr !== 16'h0201 || skipstatus !== 1'b0) begin
            bad++;
            $display("FAIL jump_skip got fetch=%b exec1=%b addr=%h skip=%b want 1 0 0201 0", fetch, exec1, mem_addr, skipstatus);
        end
    endtask
    task test_halt;
        logic [15:0] pc_hold;
        alu(1'b0, 1'b0, 16'h0);
        total++;
        if (fetch !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_no_abort got fetch=%b halted=%b want 1 0", fetch, halted); end
        alu(1'b0, 1'b1, 16'h4000);
        alu(1'b0, 1'b0, 16'h0);
        total++;
        if (exec2 !== 1'b1) begin bad++; $display("FAIL halt_completes got exec2=%b want 1", exec2); end
        alu(1'b0, 1'b0, 16'h0);
        pc_hold = mem_addr;
        alu(1'b0, 1'b1, 16'hC000);
        total++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || mem_addr !== pc_hold || pc_hold !== m_pc) begin
            bad++;
            $display("FAIL halt_idle got halted=%b req=%b addr=%h want 1 0 %h", halted, mem_req, mem_addr, m_pc);
        end
        alu(1'b1, 1'b0, 16'h0);
        total++;
        if (fetch !== 1'b1) begin bad++; $display("FAIL halt_resume got fetch=%b want 1", fetch); end
    endtask
    task test_carry_enable;
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (carrystatus !== 1'b0 || exec1 !== 1'b1) begin
            bad++;
            $display("FAIL carry_outside got carry=%b exec1=%b want 0 1", carrystatus, exec1);
        end
        tick(1'b1, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (carrystatus !== 1'b1) begin bad++; $display("FAIL carry_exec1 got carry=%b want 1", carrystatus); end
    endtask
    task test_async_reset;
        int n;
        n = 0;
        while (ex != 1 && n < 20) begin
            alu(1'b1, 1'b1, 16'hC000);
            n++;
        end
        total++;
        if (n >= 20 || exec1 !== 1'b1) begin bad++; $display("FAIL areset_reach got exec1=%b want 1", exec1); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({halted, exec1, mem_req, carrystatus, skipstatus} !== 5'b10000 || mem_addr !== RPC || ir !== 16'h0000) begin
            bad++;
            $display("FAIL areset_instant got flags=%b addr=%h ir=%h want 10000 %h 0000", {halted, exec1, mem_req, carrystatus, skipstatus}, mem_addr, ir, RPC);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task test_random;
        logic [15:0] d;
        for (int i = 0; i < 2000; i++) begin
            d = 16'($urandom);
            tick(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 9) < 7), d,
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)));
            total++;
            if ({halted, fetch, mem_req, exec1, exec2, carrystatus, skipstatus, mem_addr, ir} !==
                {m_idle, !m_idle && ex == 0, !m_idle && ex == 0, ex == 1, ex == 2, m_c, m_s, m_pc, m_ir}) begin
                bad++;
                $display("FAIL random%0d got h=%b f=%b r=%b e1=%b e2=%b c=%b s=%b pc=%h ir=%h want h=%b ex=%0d c=%b s=%b pc=%h ir=%h",
                         i, halted, fetch, mem_req, exec1, exec2, carrystatus, skipstatus, mem_addr, ir, m_idle, ex, m_c, m_s, m_pc, m_ir);
            end
        end
    endtask
    initial begin
        test_reset();
        test_alu_stream();
        test_wait_states();
        test_skip();
        test_jump_two_cycle();
        test_halt();
        test_carry_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
